// File: rtl/ece369_pipe_pkg.sv
// Shared pipeline definitions for the ECE369 MIPS datapath.
// Provides the instruction/PC widths, the architectural NOP encoding
// (sll $0,$0,0) and the IF/ID queue entry layout.
package ece369_pipe_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc4;
  } if_id_entry_t;

  localparam int ENTRY_W = $bits(if_id_entry_t);

endpackage

// File: rtl/fetch_queue_storage.sv
// Entry storage for the IF/ID fetch queue.
// DEPTH flop-based entries, one synchronous write port, one asynchronous
// read port. Data registers carry no reset; validity is tracked by the
// owner of this array.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write slot index
//   wdata  - entry to write
//   raddr  - read slot index
//   rdata  - entry at raddr (combinational from the registers)
module fetch_queue_storage
  import ece369_pipe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  if_id_entry_t             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output if_id_entry_t             rdata
);

  localparam int PTR_W = $clog2(DEPTH);

  if_id_entry_t entry_q [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    if_id_entry_t entry_reg;

    always_ff @(posedge clk) begin
      if (we && (waddr == PTR_W'(gi))) begin
        entry_reg <= wdata;
      end
    end

    assign entry_q[gi] = entry_reg;
  end

  assign rdata = entry_q[raddr];

endmodule

// File: rtl/if_id_fetch_queue.sv
// IF/ID decoupling queue.
// Captures fetched {instruction, PC+4} pairs and presents the oldest one
// to decode. Backpressures fetch only once DEPTH words are buffered; a
// taken redirect in ID (ID_flush) discards everything, including the
// word being fetched in the same cycle.
// Ports:
//   Clk, Reset      - clock, asynchronous active-high reset
//   IF_Instruction  - fetched instruction word
//   IF_PC4          - PC+4 of that word
//   IF_valid        - fetch word valid
//   ID_stall        - decode holds the head entry
//   ID_flush        - redirect: discard queued and incoming words
//   IF_stall        - queue full, fetch must hold its PC
//   ID_Instruction  - head instruction, NOP_WORD when empty
//   ID_PC4          - head PC+4, zero when empty
//   ID_valid        - head entry valid
//   occupancy       - number of buffered entries
// All outputs come from registered state only; there is no input-to-output
// combinational path.
module if_id_fetch_queue
  import ece369_pipe_pkg::*;
#(
  parameter int                 DEPTH    = 4,
  parameter logic [INSTR_W-1:0] NOP_WORD = ece369_pipe_pkg::NOP_WORD
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [INSTR_W-1:0]         IF_Instruction,
  input  logic [PC_W-1:0]            IF_PC4,
  input  logic                       IF_valid,
  input  logic                       ID_stall,
  input  logic                       ID_flush,
  output logic                       IF_stall,
  output logic [INSTR_W-1:0]         ID_Instruction,
  output logic [PC_W-1:0]            ID_PC4,
  output logic                       ID_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  if_id_entry_t wr_entry;
  if_id_entry_t head_entry;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

  // Full blocks the push even if ID pops in the same cycle: IF_stall is
  // registered, so fetch has already been told to hold this word.
  assign push = IF_valid & ~full  & ~ID_flush;
  assign pop  = ~empty   & ~ID_stall & ~ID_flush;

  assign wr_entry.instr = IF_Instruction;
  assign wr_entry.pc4   = IF_PC4;

  fetch_queue_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (Clk),
    .we    (push),
    .waddr (wr_ptr_reg),
    .wdata (wr_entry),
    .raddr (rd_ptr_reg),
    .rdata (head_entry)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (ID_flush) begin
      // Collapse to empty at the write pointer; stale slots stay hidden
      // because the outputs are gated by count.
      rd_ptr_reg <= wr_ptr_reg;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign IF_stall       = full;
  assign ID_valid       = ~empty;
  assign ID_Instruction = empty ? NOP_WORD : head_entry.instr;
  assign ID_PC4         = empty ? '0       : head_entry.pc4;
  assign occupancy      = count_reg;

  a_count_bound : assert property (@(posedge Clk) disable iff (Reset)
    count_reg <= CNT_W'(DEPTH));
  a_no_underflow : assert property (@(posedge Clk) disable iff (Reset)
    !(pop && empty));
  a_no_overflow : assert property (@(posedge Clk) disable iff (Reset)
    !(push && full));

endmodule

// File: tb/tb_if_id_fetch_queue.sv
module tb_if_id_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  logic        Clk;
  logic        Reset;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PC4;
  logic        IF_valid;
  logic        ID_stall;
  logic        ID_flush;
  logic        IF_stall;
  logic [31:0] ID_Instruction;
  logic [31:0] ID_PC4;
  logic        ID_valid;
  logic [2:0]  occupancy;

  if_id_fetch_queue #(.DEPTH(DEPTH)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .IF_Instruction (IF_Instruction),
    .IF_PC4         (IF_PC4),
    .IF_valid       (IF_valid),
    .ID_stall       (ID_stall),
    .ID_flush       (ID_flush),
    .IF_stall       (IF_stall),
    .ID_Instruction (ID_Instruction),
    .ID_PC4         (ID_PC4),
    .ID_valid       (ID_valid),
    .occupancy      (occupancy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 1'b0;
  bit verbose     = 1'b1;

  ent_t        ref_q[$];      // reference queue contents, oldest first
  logic [31:0] log_q[$];      // words the DUT actually handed to ID

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: a bounded FIFO updated from the rules (flush clears,
  // decode takes the head unless stalled, fetch appends only if not full
  // at the start of the cycle). Also logs what the DUT delivers.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ref_q.delete();
    end else begin
      int n;
      n = ref_q.size();
      if (ID_valid && !ID_stall && !ID_flush) begin
        log_q.push_back(ID_Instruction);
        if (verbose) $display("deliver instr=%h pc4=%h occ=%0d", ID_Instruction, ID_PC4, occupancy);
      end
      if (ID_flush) begin
        ref_q.delete();
      end else begin
        if (n > 0 && !ID_stall) ref_q.pop_front();
        if (IF_valid && n < DEPTH) ref_q.push_back('{IF_Instruction, IF_PC4});
      end
    end
  end

  // Monitor: compares DUT outputs against the model head each cycle.
  always @(negedge Clk) begin
    if (mon_en) begin
      chk("mon_occupancy", 32'(occupancy), 32'(ref_q.size()));
      chk("mon_if_stall", 32'(IF_stall), 32'(ref_q.size() == DEPTH));
      chk("mon_id_valid", 32'(ID_valid), 32'(ref_q.size() != 0));
      if (ref_q.size() != 0) begin
        chk("mon_head_instr", ID_Instruction, ref_q[0].instr);
        chk("mon_head_pc4", ID_PC4, ref_q[0].pc4);
      end else begin
        chk("mon_empty_instr", ID_Instruction, 32'h0);
        chk("mon_empty_pc4", ID_PC4, 32'h0);
      end
    end
  end

  // Apply one cycle of stimulus starting at a falling edge; returns at the
  // next falling edge.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic st, input logic fl);
    IF_valid       = v;
    IF_Instruction = ins;
    IF_PC4         = ins + 32'h4;
    ID_stall       = st;
    ID_flush       = fl;
    @(negedge Clk);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("drain_empty", 32'(occupancy), 32'd0);
  endtask

  logic [31:0] wlist [6];
  int          idx;
  int          bad;

  initial begin
    Reset = 1'b1;
    IF_valid = 1'b0; IF_Instruction = '0; IF_PC4 = '0; ID_stall = 1'b0; ID_flush = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_id_valid", 32'(ID_valid), 32'd0);
    chk("rst_if_stall", 32'(IF_stall), 32'd0);
    chk("rst_id_instr", ID_Instruction, 32'h0);
    chk("rst_id_pc4", ID_PC4, 32'h0);
    Reset = 1'b0;
    mon_en = 1'b1;

    // 1: streaming with one-cycle latency
    cyc(1'b1, 32'h2008_0001, 1'b0, 1'b0);
    chk("t1_instr0", ID_Instruction, 32'h2008_0001);
    chk("t1_occ0", 32'(occupancy), 32'd1);
    cyc(1'b1, 32'h2009_0002, 1'b0, 1'b0);
    chk("t1_instr1", ID_Instruction, 32'h2009_0002);
    chk("t1_valid1", 32'(ID_valid), 32'd1);
    chk("t1_occ1", 32'(occupancy), 32'd1);
    drain();

    // 2: stall fills the queue, fetch holds E/F until space frees
    for (int k = 0; k < 6; k++) wlist[k] = 32'hA000_0000 + 32'(k);
    log_q.delete();
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      logic acc;
      acc = !IF_stall;
      cyc(1'b1, wlist[idx], 1'b1, 1'b0);
      if (acc) idx++;
      chk("t2_occ", 32'(occupancy), 32'((c + 1 < DEPTH) ? c + 1 : DEPTH));
      chk("t2_if_stall", 32'(IF_stall), 32'(c >= DEPTH - 1));
    end
    chk("t2_held_idx", 32'(idx), 32'd4);
    for (int c = 0; c < 12; c++) begin
      logic acc;
      acc = !IF_stall;
      if (idx < 6) begin
        cyc(1'b1, wlist[idx], 1'b0, 1'b0);
        if (acc) idx++;
      end else begin
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
      end
    end
    chk("t2_delivered", 32'(log_q.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < log_q.size()) chk("t2_order", log_q[k], wlist[k]);
    end

    // 3: full queue with a same-cycle pop does not accept the fetch word
    for (int k = 0; k < DEPTH; k++) cyc(1'b1, 32'hB000_0000 + 32'(k), 1'b1, 1'b0);
    chk("t3_full_occ", 32'(occupancy), 32'd4);
    chk("t3_full_stall", 32'(IF_stall), 32'd1);
    cyc(1'b1, 32'hB000_00FF, 1'b0, 1'b0);
    chk("t3_pop_occ", 32'(occupancy), 32'd3);
    chk("t3_stall_drop", 32'(IF_stall), 32'd0);
    cyc(1'b1, 32'hB000_00FF, 1'b0, 1'b0);
    chk("t3_pushpop_occ", 32'(occupancy), 32'd3);
    drain();

    // 4: flush discards queued words and the concurrent fetch word
    log_q.delete();
    for (int k = 0; k < 3; k++) cyc(1'b1, 32'hC000_0000 + 32'(k), 1'b1, 1'b0);
    chk("t4_occ3", 32'(occupancy), 32'd3);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    chk("t4_valid", 32'(ID_valid), 32'd0);
    chk("t4_instr", ID_Instruction, 32'h0);
    chk("t4_occ", 32'(occupancy), 32'd0);
    chk("t4_if_stall", 32'(IF_stall), 32'd0);
    drain();
    bad = 0;
    foreach (log_q[k]) if (log_q[k] == 32'hDEAD_BEEF || log_q[k][31:28] == 4'hC) bad++;
    chk("t4_wrong_path", 32'(bad), 32'd0);

    // 5: asynchronous reset between edges
    for (int k = 0; k < 2; k++) cyc(1'b1, 32'hD000_0000 + 32'(k), 1'b1, 1'b0);
    chk("t5_occ2", 32'(occupancy), 32'd2);
    #2 Reset = 1'b1;
    #1;
    chk("t5_async_occ", 32'(occupancy), 32'd0);
    chk("t5_async_valid", 32'(ID_valid), 32'd0);
    chk("t5_async_instr", ID_Instruction, 32'h0);
    chk("t5_async_pc4", ID_PC4, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    cyc(1'b1, 32'h2010_0003, 1'b0, 1'b0);
    chk("t5_after_valid", 32'(ID_valid), 32'd1);
    chk("t5_after_instr", ID_Instruction, 32'h2010_0003);
    chk("t5_after_pc4", ID_PC4, 32'h2010_0007);
    drain();

    // 6: random traffic against the reference queue
    verbose = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      IF_valid       = ($urandom_range(3) != 0);
      IF_Instruction = $urandom();
      IF_PC4         = $urandom();
      ID_stall       = ($urandom_range(2) == 0);
      ID_flush       = ($urandom_range(15) == 0);
      @(negedge Clk);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
